// File: rtl/score_bcd_display_if.sv
// Bundle of frame trigger, score inputs and BCD display outputs between
// the score source and the HEX driver bank.
interface score_bcd_display_if #(
    parameter int SCORE_W = 10,
    parameter int DIGITS  = 4
);
    logic                  frame_clk;
    logic [SCORE_W-1:0]    score;
    logic                  show_hi;
    logic                  clear_hi;
    logic [4*DIGITS-1:0]   bcd_out;
    logic [DIGITS-1:0]     blank_n;
    logic [SCORE_W-1:0]    hi_score;
    logic                  busy;
    logic                  valid;

    modport master (
        output frame_clk, score, show_hi, clear_hi,
        input  bcd_out, blank_n, hi_score, busy, valid
    );

    modport slave (
        input  frame_clk, score, show_hi, clear_hi,
        output bcd_out, blank_n, hi_score, busy, valid
    );
endinterface

// File: rtl/score_bcd_display.sv
// Once per frame: update the session high score, then convert the selected
// score to packed BCD with a sequential double-dabble engine.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module score_bcd_display #(
    parameter int SCORE_W = 10,
    parameter int DIGITS  = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    score_bcd_display_if.slave   bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SH_W  = BCD_W + SCORE_W;
    localparam int CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t               state_q, state_d;
    logic                 frame_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SH_W-1:0]      sh_q, sh_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic [DIGITS-1:0]    blank_q, blank_d, blank_calc;
    logic [SCORE_W-1:0]   hi_q, hi_d, hi_cand;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic                 rise;
    logic [BCD_W-1:0]     bcd_adj;

    assign rise    = bus.frame_clk & ~frame_d;
    assign hi_cand = bus.clear_hi ? '0 : ((bus.score > hi_q) ? bus.score : hi_q);

    // Per-digit add-3 correction, all nibbles in parallel
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d (sh_q[SCORE_W + 4*g +: 4]),
            .q (bcd_adj[4*g +: 4])
        );
    end

    // A digit stays lit if it or any more significant digit is nonzero
    always_comb begin
        logic any_nz;
        any_nz     = 1'b0;
        blank_calc = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            any_nz        = any_nz | (sh_q[SCORE_W + 4*i +: 4] != 4'd0);
            blank_calc[i] = any_nz;
        end
        blank_calc[0] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        blank_d = blank_q;
        hi_d    = bus.clear_hi ? '0 : hi_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    hi_d    = hi_cand;
                    sh_d    = {{BCD_W{1'b0}}, (bus.show_hi ? hi_cand : bus.score)};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                sh_d  = {bcd_adj, sh_q[SCORE_W-1:0]} << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SCORE_W - 1))
                    state_d = DONE;
            end
            DONE: begin
                bcd_d   = sh_q[SH_W-1:SCORE_W];
                blank_d = blank_calc;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // frame_d resets high so a level already high at reset release is not an edge
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            frame_d <= 1'b1;
            cnt_q   <= '0;
            sh_q    <= '0;
            bcd_q   <= '0;
            blank_q <= DIGITS'(1);
            hi_q    <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_d <= bus.frame_clk;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            blank_q <= blank_d;
            hi_q    <= hi_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign bus.bcd_out  = bcd_q;
    assign bus.blank_n  = blank_q;
    assign bus.hi_score = hi_q;
    assign bus.busy     = busy_q;
    assign bus.valid    = valid_q;
endmodule
